// File: rtl/router_input_queue.sv
// router_input_queue
// Input-side FIFO of a router port. Each message carries its destination in
// the top bits; the head entry is steered to one downstream port through a
// one-hot valid vector. Heads addressed to a port that does not exist are
// discarded and tallied in a wrapping 8-bit drop counter.
module router_input_queue #(
    parameter int p_nbits    = 8,
    parameter int p_noutputs = 4,
    parameter int p_depth    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_nbits-1:0]            recv_msg,
    input  logic                          recv_val,
    output logic                          recv_rdy,
    output logic [p_nbits-1:0]            send_msg,
    output logic [$clog2(p_noutputs)-1:0] send_sel,
    output logic [p_noutputs-1:0]         send_val,
    input  logic [p_noutputs-1:0]         send_rdy,
    output logic [$clog2(p_depth):0]      count,
    output logic [7:0]                    drop_count
);

    localparam int SELW = $clog2(p_noutputs);
    localparam int PTRW = $clog2(p_depth);
    localparam int CNTW = PTRW + 1;

    // Entry storage; never reset, since occupancy alone decides what is live.
    logic [p_nbits-1:0] r_mem [p_depth];

    logic [PTRW-1:0]    r_head;
    logic [PTRW-1:0]    r_tail;
    logic [CNTW-1:0]    r_count;
    logic [7:0]         r_drop;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_deq;
    logic               w_discard;
    logic               w_pop;
    logic [p_nbits-1:0] w_head_msg;
    logic [SELW-1:0]    w_dest;
    logic [p_noutputs-1:0] w_send_val;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNTW'(p_depth));
    assign w_head_msg = r_mem[r_head];
    assign w_dest     = w_head_msg[p_nbits-1 -: SELW];

    // One valid bit per existing port. A destination code beyond the last
    // port matches no bit, which is exactly the condition for discarding.
    generate
        for (genvar gi = 0; gi < p_noutputs; gi++) begin : g_port_val
            assign w_send_val[gi] = !w_empty && (w_dest == SELW'(gi));
        end
    endgenerate

    // Full blocks enqueue outright, even when the head leaves the same cycle.
    assign w_push    = recv_val && !w_full;
    assign w_deq     = |(w_send_val & send_rdy);
    assign w_discard = !w_empty && !(|w_send_val);
    assign w_pop     = w_deq || w_discard;

    assign recv_rdy   = !w_full;
    assign send_val   = w_send_val;
    assign send_msg   = w_empty ? '0 : w_head_msg;
    assign send_sel   = w_empty ? '0 : w_dest;
    assign count      = r_count;
    assign drop_count = r_drop;

    // Write accepted messages at the tail slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= recv_msg;
        end
    end

    // Pointer, occupancy and drop bookkeeping; pointers wrap naturally
    // because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTRW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTRW'(1);
            end
            if (w_discard) begin
                r_drop <= r_drop + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_queue.sv
// Bench for router_input_queue: a default-parameter instance checked through
// an expected-output scoreboard, plus a 3-port instance for discard handling.
module tb_router_input_queue;

    logic clk;
    logic rst;

    // Instance A: 8-bit messages, 4 outputs, depth 4
    logic [7:0] a_recv_msg;
    logic       a_recv_val;
    logic       a_recv_rdy;
    logic [7:0] a_send_msg;
    logic [1:0] a_send_sel;
    logic [3:0] a_send_val;
    logic [3:0] a_send_rdy;
    logic [2:0] a_count;
    logic [7:0] a_drop;

    // Instance B: 8-bit messages, 3 outputs, depth 4
    logic [7:0] b_recv_msg;
    logic       b_recv_val;
    logic       b_recv_rdy;
    logic [7:0] b_send_msg;
    logic [1:0] b_send_sel;
    logic [2:0] b_send_val;
    logic [2:0] b_send_rdy;
    logic [2:0] b_count;
    logic [7:0] b_drop;

    router_input_queue #(.p_nbits(8), .p_noutputs(4), .p_depth(4)) dut_a (
        .clk(clk), .reset(rst),
        .recv_msg(a_recv_msg), .recv_val(a_recv_val), .recv_rdy(a_recv_rdy),
        .send_msg(a_send_msg), .send_sel(a_send_sel), .send_val(a_send_val),
        .send_rdy(a_send_rdy), .count(a_count), .drop_count(a_drop)
    );

    router_input_queue #(.p_nbits(8), .p_noutputs(3), .p_depth(4)) dut_b (
        .clk(clk), .reset(rst),
        .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
        .send_msg(b_send_msg), .send_sel(b_send_sel), .send_val(b_send_val),
        .send_rdy(b_send_rdy), .count(b_count), .drop_count(b_drop)
    );

    typedef struct packed {
        logic [7:0] msg;
        logic [3:0] val;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s = 0x%0h t=%0t", name, act, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_a(input logic [7:0] msg, input logic [3:0] val, input logic [1:0] sel);
        a_recv_msg = msg;
        a_recv_val = 1'b1;
        exp_q.push_back('{msg: msg, val: val, sel: sel});
    endtask

    // Monitor: every handshake on instance A consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (|(a_send_val & a_send_rdy))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual msg=0x%0h val=%b required none t=%0t",
                             a_send_msg, a_send_val, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_msg", 32'(a_send_msg), 32'(e.msg));
                    check("sb_val", 32'(a_send_val), 32'(e.val));
                    check("sb_sel", 32'(a_send_sel), 32'(e.sel));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        a_recv_msg = '0; a_recv_val = 1'b0; a_send_rdy = '0;
        b_recv_msg = '0; b_recv_val = 1'b0; b_send_rdy = '0;
        #2;
        check("rst_count",    32'(a_count),    0);
        check("rst_recv_rdy", 32'(a_recv_rdy), 1);
        check("rst_send_val", 32'(a_send_val), 0);
        check("rst_send_msg", 32'(a_send_msg), 0);
        check("rst_send_sel", 32'(a_send_sel), 0);
        check("rst_drop",     32'(a_drop),     0);
        step();
        rst = 1'b0;

        // Single message, all ports ready: one-cycle latency, immediate drain
        a_send_rdy = 4'b1111;
        enq_a(8'h85, 4'b0100, 2'd2);
        step();
        a_recv_val = 1'b0;
        check("lat_send_val", 32'(a_send_val), 32'h4);
        check("lat_count",    32'(a_count),    1);
        step();
        check("drain_count",  32'(a_count),    0);

        // Fill to full with nothing ready, fifth message refused
        a_send_rdy = 4'b0000;
        enq_a(8'h01, 4'b0001, 2'd0); step();
        enq_a(8'h42, 4'b0010, 2'd1); step();
        enq_a(8'h83, 4'b0100, 2'd2); step();
        enq_a(8'hC4, 4'b1000, 2'd3); step();
        check("full_count",    32'(a_count),    4);
        check("full_recv_rdy", 32'(a_recv_rdy), 0);
        a_recv_msg = 8'h07;
        a_recv_val = 1'b1;
        step();
        a_recv_val = 1'b0;
        check("reject_count", 32'(a_count), 4);
        a_send_rdy = 4'b1111;
        repeat (4) step();
        check("empty_count", 32'(a_count), 0);

        // Head-of-line blocking: other ports ready, own port not
        a_send_rdy = 4'b1011;
        enq_a(8'h85, 4'b0100, 2'd2);
        step();
        a_recv_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hol_send_val", 32'(a_send_val), 32'h4);
            check("hol_send_msg", 32'(a_send_msg), 32'h85);
            check("hol_count",    32'(a_count),    1);
            step();
        end
        a_send_rdy = 4'b0100;
        step();
        check("hol_release_count", 32'(a_count), 0);

        // Simultaneous enqueue and dequeue around the pointer wrap
        a_send_rdy = 4'b0000;
        enq_a(8'h10, 4'b0001, 2'd0); step();
        enq_a(8'h51, 4'b0010, 2'd1); step();
        check("sim_pre_count", 32'(a_count), 2);
        a_send_rdy = 4'b0001;
        enq_a(8'h92, 4'b0100, 2'd2); step();
        check("sim1_count", 32'(a_count),    2);
        check("sim1_head",  32'(a_send_msg), 32'h51);
        a_send_rdy = 4'b0010;
        enq_a(8'hD3, 4'b1000, 2'd3); step();
        check("sim2_count", 32'(a_count),    2);
        check("sim2_head",  32'(a_send_msg), 32'h92);
        a_recv_val = 1'b0;
        a_send_rdy = 4'b1111;
        step();
        step();
        check("sim_drain_count", 32'(a_count), 0);

        // Reset between edges with three messages queued
        a_send_rdy = 4'b0000;
        enq_a(8'h01, 4'b0001, 2'd0); step();
        enq_a(8'h02, 4'b0001, 2'd0); step();
        enq_a(8'h03, 4'b0001, 2'd0); step();
        a_recv_val = 1'b0;
        check("pre_rst_count", 32'(a_count), 3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_count",    32'(a_count),    0);
        check("arst_recv_rdy", 32'(a_recv_rdy), 1);
        check("arst_send_val", 32'(a_send_val), 0);
        check("arst_send_msg", 32'(a_send_msg), 0);
        rst = 1'b0;
        a_send_rdy = 4'b1111;
        enq_a(8'h42, 4'b0010, 2'd1);
        step();
        a_recv_val = 1'b0;
        check("post_rst_send_val", 32'(a_send_val), 32'h2);
        step();
        check("post_rst_count", 32'(a_count), 0);
        repeat (3) step();

        // Instance B: destination 3 does not exist and is discarded
        b_send_rdy = 3'b000;
        b_recv_msg = 8'hC0;
        b_recv_val = 1'b1;
        step();
        b_recv_msg = 8'h40;
        check("b_bad_send_val", 32'(b_send_val), 0);
        check("b_bad_count",    32'(b_count),    1);
        step();
        b_recv_val = 1'b0;
        check("b_drop1",     32'(b_drop),     1);
        check("b_count1",    32'(b_count),    1);
        check("b_send_val",  32'(b_send_val), 32'h2);
        check("b_send_msg",  32'(b_send_msg), 32'h40);
        check("b_send_sel",  32'(b_send_sel), 1);
        b_send_rdy = 3'b111;
        step();
        check("b_drain_count", 32'(b_count), 0);

        // Drive drop_count through its wrap
        b_recv_msg = 8'hC0;
        b_recv_val = 1'b1;
        repeat (255) step();
        check("b_drop255", 32'(b_drop),  255);
        check("b_count_w", 32'(b_count), 1);
        b_recv_val = 1'b0;
        step();
        check("b_drop_wrap",  32'(b_drop),  0);
        check("b_wrap_count", 32'(b_count), 0);

        check("sb_leftover", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
